seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Parametrised multiplexed seven-segment display driver: the next generation of the stopwatch display path. It scans `NUM_DIGITS` BCD digits with decimal points and supports selectable output polarity, leading-zero blanking, per-digit blink and PWM brightness control, plus an alarm LED that blinks. It sits between the timekeeping/BCD counters and the board pins, and is driven by the shared scan- and blink-tick enable generators.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned (2..8); digit 0 is rightmost.
- `SEG_ACTIVE_HIGH`, 1: 1 = segment/DP lit by high; 0 = lit by low.
- `AN_ACTIVE_HIGH`, 1: 1 = digit select active high; 0 = active low.
- `DIM_BITS`, 3: width of the brightness control and PWM phase counter.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `digits_in`  in  4*NUM_DIGITS  BCD nibbles; nibble i maps to digit i.
- `dp_in`  in  NUM_DIGITS  decimal-point request per digit.
- `blank_lz_in`  in  1  enable leading-zero blanking.
- `blink_mask_in`  in  NUM_DIGITS  1 = digit blinks.
- `brightness_in`  in  DIM_BITS  duty setting; all-ones = full on.
- `scan_tick_in`  in  1  one-cycle pulse; advances to the next digit.
- `blink_tick_in`  in  1  one-cycle pulse; toggles the blink phase.
- `alarm_active_in`  in  1  alarm condition.
- `seg_out`  out  7  segments, `[6]`=G … `[0]`=A, polarity per `SEG_ACTIVE_HIGH`.
- `dp_out`  out  1  decimal point, same polarity as `seg_out`.
- `an_out`  out  NUM_DIGITS  one-hot digit select, polarity per `AN_ACTIVE_HIGH`.
- `led_alarm_out`  out  1  alarm LED, active high.

## Operation
- **Scan index.** `idx` counts 0..NUM_DIGITS-1.
  - It advances on each `scan_tick_in` and wraps from NUM_DIGITS-1 to 0.
  - Non-power-of-2 digit counts must wrap exactly; no phantom slots.
- **Frame snapshot.** `digits_in` and `dp_in` are captured into frame registers on the edge where `scan_tick_in`=1 and `idx`=NUM_DIGITS-1.
  - A whole frame therefore shows one coherent value, with no tearing.
  - Inputs are not sampled at any other time.
- **Leading-zero blanking.** Computed from the snapshot. When `blank_lz_in`=1, digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked, up to the first non-zero nibble.
  - Digit 0 is never blanked by this rule.
  - A blanked digit's DP still follows `dp_in`.
- **Decode.**
  - 0–9: standard glyphs (0 = A–F, 1 = B,C, …, 9 = A,B,C,D,F,G).
  - 4'hF: blank.
  - 4'hA–4'hE: '-' (G only).
- **Blink.** `blink_phase` toggles on `blink_tick_in`. Digits with `blink_mask_in` bit set are fully blanked, DP included, while `blink_phase`=1.
- **Brightness.**
  - `pwm_cnt` (DIM_BITS wide) increments every clock and is cleared on `scan_tick_in`.
  - The digit is driven only while `pwm_cnt` <= `brightness_in`.
  - 0 gives minimum duty 1/2^DIM_BITS; `brightness_in` is sampled every cycle.
- **Ghost blanking.** For the first clock after every `scan_tick_in`, all `an_out` are inactive.
- **Blanked digit.** Any blank condition drives `seg_out`/`dp_out` inactive while `an_out` still selects the digit.
- **Alarm LED.** `led_alarm_out` = `blink_phase` while `alarm_active_in`=1; otherwise 0.
- **Simultaneous events.** `scan_tick_in` and `blink_tick_in` in the same cycle both take effect.

## Timing
- All outputs are registered.
- **Reset values.**
  - `seg_out`, `dp_out`, `an_out` all at their inactive level.
  - `led_alarm_out`=0.
  - `idx`=0, `pwm_cnt`=0, `blink_phase`=0; frame registers and ghost flag = 0.
- **Scan tick latency.**
  - Tick sampled at edge N: `an_out` is all inactive after edge N+1.
  - The new digit is selected after edge N+2.
- **Brightness latency.** A change in `brightness_in` appears at the outputs one clock later.
- **Alarm latency.**
  - `alarm_active_in` deassertion: `led_alarm_out`=0 after the next edge.
  - `blink_tick_in`: the LED follows the new phase two edges later.
- **Reset mid-frame.** Outputs go inactive immediately (asynchronously). Scanning restarts at digit 0 showing snapshot 0 until the first frame wrap.

## Structure
- Package `seg7_pkg`:
  - segment bit positions;
  - glyph constants (`SEG7_BLANK`, `SEG7_DASH`, digit glyphs);
  - `function seg7_decode(nibble)`, returning active-high segments.
- Polarity inversion is applied once, at the output registers.
- Sub-module `seg7_lz_blank`: combinational leading-zero mask generator, NUM_DIGITS-parametrised. It is the only natural split; everything else stays in one module.

## Test plan
- **Reset and basic scan.** Reset; `digits_in`=16'h1234, scan tick every 16 clocks.
  - After the first wrap, `an_out` cycles 0001→0010→0100→1000.
  - `seg_out` is 0x66/0x4F/0x5B/0x06 for the matching digits 4/3/2/1.
  - An all-zero `an_out` appears for one clock after each tick.
- **Snapshot coherence.** Change `digits_in` from 16'h1234 to 16'h5678 while digit 1 is shown. Digits 2–3 still show 2 and 1; 5678 appears only after the wrap.
- **Leading-zero blanking.** `digits_in`=16'h0040, `blank_lz_in`=1.
  - Digits 3 and 2 show 0x00; digit 1 shows 0x66; digit 0 shows 0x3F.
  - With 16'h0000, only digit 0 is lit.
- **Brightness.**
  - `DIM_BITS`=3, `brightness_in`=2, 64 clocks per slot: the digit is selected for 3 of every 8 clocks.
  - `brightness_in`=7: selected continuously except the ghost clock.
- **Blink and alarm.**
  - `blink_mask_in`=4'b0001 with blink ticks: digit 0's segments go dark on alternate phases; other digits are unaffected.
  - `alarm_active_in`=1: `led_alarm_out` toggles per tick; it drops to 0 one clock after deassertion.
- **Parameters.** `NUM_DIGITS`=6, `SEG_ACTIVE_HIGH`=0, `AN_ACTIVE_HIGH`=0.
  - The index wraps after 6 ticks.
  - Outputs are inverted; at reset `an_out`=6'b111111 and `seg_out`=7'h7F.

Source files
------------

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Brief  : Segment bit positions, glyph constants and BCD-to-segment decoder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Glyphs are active-high; bit 6 = G ... bit 0 = A.
   localparam logic [6:0] SEG7_BLANK   = 7'h00;
   localparam logic [6:0] SEG7_DASH    = 7'h40;
   localparam logic [6:0] SEG7_DIGIT_0 = 7'h3F;
   localparam logic [6:0] SEG7_DIGIT_1 = 7'h06;
   localparam logic [6:0] SEG7_DIGIT_2 = 7'h5B;
   localparam logic [6:0] SEG7_DIGIT_3 = 7'h4F;
   localparam logic [6:0] SEG7_DIGIT_4 = 7'h66;
   localparam logic [6:0] SEG7_DIGIT_5 = 7'h6D;
   localparam logic [6:0] SEG7_DIGIT_6 = 7'h7D;
   localparam logic [6:0] SEG7_DIGIT_7 = 7'h07;
   localparam logic [6:0] SEG7_DIGIT_8 = 7'h7F;
   localparam logic [6:0] SEG7_DIGIT_9 = 7'h6F;

   function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
      logic [6:0] glyph;
      case (nibble)
         4'h0:    glyph = SEG7_DIGIT_0;
         4'h1:    glyph = SEG7_DIGIT_1;
         4'h2:    glyph = SEG7_DIGIT_2;
         4'h3:    glyph = SEG7_DIGIT_3;
         4'h4:    glyph = SEG7_DIGIT_4;
         4'h5:    glyph = SEG7_DIGIT_5;
         4'h6:    glyph = SEG7_DIGIT_6;
         4'h7:    glyph = SEG7_DIGIT_7;
         4'h8:    glyph = SEG7_DIGIT_8;
         4'h9:    glyph = SEG7_DIGIT_9;
         4'hF:    glyph = SEG7_BLANK;
         default: glyph = SEG7_DASH;
      endcase
      return glyph;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
// ============================================================================
// Module : seg7_scan_driver_if
// Brief  : Display data, tick and pin bundle between BCD source and driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4,
   parameter int DIM_BITS   = 3
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz_in;
   logic [NUM_DIGITS-1:0]   blink_mask_in;
   logic [DIM_BITS-1:0]     brightness_in;
   logic                    scan_tick_in;
   logic                    blink_tick_in;
   logic                    alarm_active_in;
   logic [6:0]              seg_out;
   logic                    dp_out;
   logic [NUM_DIGITS-1:0]   an_out;
   logic                    led_alarm_out;

   modport master (
      output digits_in, dp_in, blank_lz_in, blink_mask_in, brightness_in,
             scan_tick_in, blink_tick_in, alarm_active_in,
      input  seg_out, dp_out, an_out, led_alarm_out
   );

   modport slave (
      input  digits_in, dp_in, blank_lz_in, blink_mask_in, brightness_in,
             scan_tick_in, blink_tick_in, alarm_active_in,
      output seg_out, dp_out, an_out, led_alarm_out
   );
endinterface

`default_nettype wire

// File: rtl/seg7_lz_blank.sv
// ============================================================================
// Module : seg7_lz_blank
// Brief  : Combinational leading-zero blank mask; digit 0 is never blanked.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_lz_blank #(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic                    enable_i,
   output logic [NUM_DIGITS-1:0]   blank_o
);

   logic [NUM_DIGITS-1:0] lead_zero;

   // Each digit is a leading zero when it and every digit above it are zero.
   generate
      for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lead
         assign lead_zero[i] = (digits_i[4*NUM_DIGITS-1:4*i] == '0);
      end
   endgenerate

   assign blank_o = enable_i ? {lead_zero[NUM_DIGITS-1:1], 1'b0}
                             : {NUM_DIGITS{1'b0}};

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module : seg7_scan_driver
// Brief  : Multiplexed 7-segment scanner with snapshot, LZ blank, blink, PWM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS      = 4,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int AN_ACTIVE_HIGH  = 1,
   parameter int DIM_BITS        = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   seg7_scan_driver_if.slave bus
);

   localparam int                    IDX_W      = $clog2(NUM_DIGITS);
   localparam logic [IDX_W-1:0]      c_LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            c_SEG_OFF  = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;
   localparam logic                  c_DP_OFF   = (SEG_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
   localparam logic [NUM_DIGITS-1:0] c_AN_OFF   = (AN_ACTIVE_HIGH != 0) ?
                                                  {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};

   logic [IDX_W-1:0]        idx_q,         idx_d;
   logic [4*NUM_DIGITS-1:0] frame_dig_q,   frame_dig_d;
   logic [NUM_DIGITS-1:0]   frame_dp_q,    frame_dp_d;
   logic                    blink_phase_q, blink_phase_d;
   logic [DIM_BITS-1:0]     pwm_cnt_q,     pwm_cnt_d;
   logic                    ghost_q,       ghost_d;
   logic [6:0]              seg_q,         seg_d;
   logic                    dp_q,          dp_d;
   logic [NUM_DIGITS-1:0]   an_q,          an_d;
   logic                    led_q,         led_d;

   logic                    frame_wrap;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_nib;
   logic                    blink_hit;
   logic                    pwm_on;
   logic [6:0]              seg_act;
   logic                    dp_act;
   logic [NUM_DIGITS-1:0]   an_act;

   seg7_lz_blank #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_lz_blank (
      .digits_i (frame_dig_q),
      .enable_i (bus.blank_lz_in),
      .blank_o  (lz_mask)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_q         <= '0;
         frame_dig_q   <= '0;
         frame_dp_q    <= '0;
         blink_phase_q <= 1'b0;
         pwm_cnt_q     <= '0;
         ghost_q       <= 1'b0;
         seg_q         <= c_SEG_OFF;
         dp_q          <= c_DP_OFF;
         an_q          <= c_AN_OFF;
         led_q         <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         frame_dig_q   <= frame_dig_d;
         frame_dp_q    <= frame_dp_d;
         blink_phase_q <= blink_phase_d;
         pwm_cnt_q     <= pwm_cnt_d;
         ghost_q       <= ghost_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         led_q         <= led_d;
      end
   end

   // Inputs are captured only on the wrap tick so a whole frame is coherent.
   always_comb begin
      frame_wrap    = bus.scan_tick_in && (idx_q == c_LAST_IDX);
      idx_d         = idx_q;
      frame_dig_d   = frame_dig_q;
      frame_dp_d    = frame_dp_q;
      if (bus.scan_tick_in) begin
         idx_d = frame_wrap ? '0 : idx_q + 1'b1;
      end
      if (frame_wrap) begin
         frame_dig_d = bus.digits_in;
         frame_dp_d  = bus.dp_in;
      end
      blink_phase_d = blink_phase_q ^ bus.blink_tick_in;
      pwm_cnt_d     = bus.scan_tick_in ? '0 : pwm_cnt_q + 1'b1;
      ghost_d       = bus.scan_tick_in;
   end

   always_comb begin
      cur_nib   = frame_dig_q[{idx_q, 2'b00} +: 4];
      blink_hit = blink_phase_q & bus.blink_mask_in[idx_q];
      seg_act   = seg7_decode(cur_nib);
      if (lz_mask[idx_q] || blink_hit) begin
         seg_act = SEG7_BLANK;
      end
      dp_act    = frame_dp_q[idx_q] & ~blink_hit;
      pwm_on    = (pwm_cnt_q <= bus.brightness_in);
      an_act    = '0;
      if (!ghost_q && pwm_on) begin
         an_act = NUM_DIGITS'(1) << idx_q;
      end
      // Polarity is resolved here, once, right before the output registers.
      seg_d = (SEG_ACTIVE_HIGH != 0) ? seg_act : ~seg_act;
      dp_d  = (SEG_ACTIVE_HIGH != 0) ? dp_act  : ~dp_act;
      an_d  = (AN_ACTIVE_HIGH  != 0) ? an_act  : ~an_act;
      led_d = bus.alarm_active_in & blink_phase_q;
   end

   assign bus.seg_out       = seg_q;
   assign bus.dp_out        = dp_q;
   assign bus.an_out        = an_q;
   assign bus.led_alarm_out = led_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module : tb_seg7_scan_driver
// Brief  : Directed self-checking bench for seg7_scan_driver (4- and 6-digit).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic            lz;
      logic [3:0][6:0] seg;
      logic [3:0]      exp_dp;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(4), .DIM_BITS(3)) bus_a ();
   seg7_scan_driver_if #(.NUM_DIGITS(6), .DIM_BITS(3)) bus_b ();

   seg7_scan_driver #(
      .NUM_DIGITS(4), .SEG_ACTIVE_HIGH(1), .AN_ACTIVE_HIGH(1), .DIM_BITS(3)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(bus_a)
   );

   seg7_scan_driver #(
      .NUM_DIGITS(6), .SEG_ACTIVE_HIGH(0), .AN_ACTIVE_HIGH(0), .DIM_BITS(3)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(bus_b)
   );

   int   checks = 0;
   int   errors = 0;
   int   idx_a  = 0;
   int   idx_b  = 0;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick_a(input bit with_blink = 1'b0);
      bus_a.scan_tick_in  = 1'b1;
      bus_a.blink_tick_in = with_blink;
      @(negedge clk);
      bus_a.scan_tick_in  = 1'b0;
      bus_a.blink_tick_in = 1'b0;
      idx_a = (idx_a == 3) ? 0 : idx_a + 1;
      @(negedge clk);
      check("a_ghost_an", 32'(bus_a.an_out), 32'h0);
      @(negedge clk);
   endtask

   task automatic frame_start_a();
      do tick_a(); while (idx_a != 0);
   endtask

   task automatic blink_a();
      bus_a.blink_tick_in = 1'b1;
      @(negedge clk);
      bus_a.blink_tick_in = 1'b0;
   endtask

   task automatic check_slot_a(input string tag, input logic [6:0] eseg, input logic edp);
      logic [3:0] oh;
      oh = 4'b0001 << idx_a;
      check({tag, "_an"},  32'(bus_a.an_out),  32'(oh));
      check({tag, "_seg"}, 32'(bus_a.seg_out), 32'(eseg));
      check({tag, "_dp"},  32'(bus_a.dp_out),  32'(edp));
   endtask

   task automatic tick_b();
      bus_b.scan_tick_in = 1'b1;
      @(negedge clk);
      bus_b.scan_tick_in = 1'b0;
      idx_b = (idx_b == 5) ? 0 : idx_b + 1;
      @(negedge clk);
      check("b_ghost_an", 32'(bus_b.an_out), 32'h3F);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0]      oh;
      logic [5:0]      oh_b;
      logic [6:0]      b_seg [6];
      logic            exp_on;

      // {digits, dp_in, blank_lz, segs {d3,d2,d1,d0}, expected dp}
      vecs[0] = '{16'h1234, 4'h0, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0};
      vecs[1] = '{16'h0040, 4'h0, 1'b1, {7'h00, 7'h00, 7'h66, 7'h3F}, 4'h0};
      vecs[2] = '{16'h0000, 4'h0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'h0};
      vecs[3] = '{16'h0000, 4'h0, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'h0};
      vecs[4] = '{16'h9A5F, 4'hA, 1'b1, {7'h6F, 7'h40, 7'h6D, 7'h00}, 4'hA};
      vecs[5] = '{16'h0807, 4'h8, 1'b1, {7'h00, 7'h7F, 7'h3F, 7'h07}, 4'h8};
      vecs[6] = '{16'hE6C0, 4'h0, 1'b1, {7'h40, 7'h7D, 7'h40, 7'h3F}, 4'h0};
      b_seg   = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

      reset_n = 1'b0;
      bus_a.digits_in = '0;       bus_a.dp_in = '0;         bus_a.blank_lz_in = 1'b0;
      bus_a.blink_mask_in = '0;   bus_a.brightness_in = 3'd7;
      bus_a.scan_tick_in = 1'b0;  bus_a.blink_tick_in = 1'b0; bus_a.alarm_active_in = 1'b0;
      bus_b.digits_in = '0;       bus_b.dp_in = '0;         bus_b.blank_lz_in = 1'b0;
      bus_b.blink_mask_in = '0;   bus_b.brightness_in = 3'd7;
      bus_b.scan_tick_in = 1'b0;  bus_b.blink_tick_in = 1'b0; bus_b.alarm_active_in = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_a_an",  32'(bus_a.an_out),        32'h0);
      check("rst_a_seg", 32'(bus_a.seg_out),       32'h0);
      check("rst_a_dp",  32'(bus_a.dp_out),        32'h0);
      check("rst_a_led", 32'(bus_a.led_alarm_out), 32'h0);
      check("rst_b_an",  32'(bus_b.an_out),        32'h3F);
      check("rst_b_seg", 32'(bus_b.seg_out),       32'h7F);
      check("rst_b_dp",  32'(bus_b.dp_out),        32'h1);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven frames: digits d0..d3 shown in scan order after a wrap
      for (int v = 0; v < 7; v++) begin
         bus_a.digits_in   = vecs[v].digits;
         bus_a.dp_in       = vecs[v].dp;
         bus_a.blank_lz_in = vecs[v].lz;
         frame_start_a();
         for (int d = 0; d < 4; d++) begin
            if (d != 0) tick_a();
            check_slot_a($sformatf("vec%0d_d%0d", v, d), vecs[v].seg[d], vecs[v].exp_dp[d]);
         end
      end

      // Snapshot coherence: input change mid-frame shows only after the wrap
      bus_a.digits_in = 16'h1234; bus_a.dp_in = '0; bus_a.blank_lz_in = 1'b0;
      frame_start_a();
      tick_a();
      check_slot_a("coh_d1", 7'h4F, 1'b0);
      bus_a.digits_in = 16'h5678;
      tick_a(); check_slot_a("coh_d2", 7'h5B, 1'b0);
      tick_a(); check_slot_a("coh_d3", 7'h06, 1'b0);
      tick_a(); check_slot_a("coh_new_d0", 7'h7F, 1'b0);
      tick_a(); check_slot_a("coh_new_d1", 7'h07, 1'b0);

      // Brightness: per-clock select pattern across a long slot
      for (int pass = 0; pass < 2; pass++) begin
         bus_a.brightness_in = (pass == 0) ? 3'd2 : 3'd7;
         bus_a.scan_tick_in  = 1'b1;
         @(negedge clk);
         bus_a.scan_tick_in  = 1'b0;
         idx_a = (idx_a == 3) ? 0 : idx_a + 1;
         oh = 4'b0001 << idx_a;
         for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            exp_on = (k != 0) && ((k % 8) <= ((pass == 0) ? 2 : 7));
            check($sformatf("pwm%0d_k%0d", pass, k), 32'(bus_a.an_out),
                  exp_on ? 32'(oh) : 32'h0);
         end
      end

      // Blink: digit 0 dark (DP too) on phase 1, other digits unaffected
      bus_a.digits_in = 16'h1234; bus_a.dp_in = 4'b0001; bus_a.blink_mask_in = 4'b0001;
      blink_a();
      frame_start_a();
      check_slot_a("blink_d0_dark", 7'h00, 1'b0);
      tick_a();
      check_slot_a("blink_d1_on", 7'h4F, 1'b0);
      tick_a(1'b1);
      check_slot_a("simul_d2", 7'h5B, 1'b0);
      frame_start_a();
      check_slot_a("blink_d0_lit", 7'h66, 1'b1);

      // Alarm LED follows blink phase; drops one clock after deassertion
      bus_a.alarm_active_in = 1'b1;
      @(negedge clk);
      check("alarm_ph0", 32'(bus_a.led_alarm_out), 32'h0);
      blink_a(); @(negedge clk);
      check("alarm_ph1", 32'(bus_a.led_alarm_out), 32'h1);
      blink_a(); @(negedge clk);
      check("alarm_ph0b", 32'(bus_a.led_alarm_out), 32'h0);
      blink_a(); @(negedge clk);
      check("alarm_ph1b", 32'(bus_a.led_alarm_out), 32'h1);
      bus_a.alarm_active_in = 1'b0;
      @(negedge clk);
      check("alarm_off", 32'(bus_a.led_alarm_out), 32'h0);

      // Asynchronous reset mid-frame, then restart on snapshot 0
      bus_a.blank_lz_in = 1'b1;
      tick_a();
      #2 reset_n = 1'b0;
      #1;
      check("arst_a_an",  32'(bus_a.an_out),  32'h0);
      check("arst_a_seg", 32'(bus_a.seg_out), 32'h0);
      check("arst_b_an",  32'(bus_b.an_out),  32'h3F);
      @(negedge clk);
      reset_n = 1'b1;
      idx_a = 0;
      idx_b = 0;
      @(negedge clk);
      check_slot_a("post_rst_d0", 7'h3F, 1'b0);
      tick_a();
      check_slot_a("post_rst_d1", 7'h00, 1'b0);

      // Six-digit inverted-polarity instance
      bus_b.digits_in = 24'h654321;
      do tick_b(); while (idx_b != 0);
      for (int d = 0; d < 6; d++) begin
         if (d != 0) tick_b();
         oh_b = ~(6'b000001 << d);
         check($sformatf("b_d%0d_an", d),  32'(bus_b.an_out),  32'(oh_b));
         check($sformatf("b_d%0d_seg", d), 32'(bus_b.seg_out), 32'(b_seg[d]));
         check($sformatf("b_d%0d_dp", d),  32'(bus_b.dp_out),  32'h1);
      end
      tick_b();
      check("b_wrap_an",  32'(bus_b.an_out),  32'h3E);
      check("b_wrap_seg", 32'(bus_b.seg_out), 32'h79);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
